pwm_multi_ch: RTL

- Parametrised multi-channel PWM generator driving the drone ESC/motor inputs.
- Successor to the single-channel pwm core: N channels share one timebase.
- Adds a programmable period and prescaler, double-buffered duty registers, per-channel duty clamping, a kill (failsafe) input and a period-start strobe.
- Sits behind the register/command interface that the host BFM drives.

---
 rtl/pwm_multi_ch_if.sv | 12 +
 rtl/pwm_multi_ch.sv | 139 +++++++++++++
 2 files changed

// File: rtl/pwm_multi_ch_if.sv
// Write bus for pwm_multi_ch: single-cycle strobe selecting a duty or the period register.
interface pwm_multi_ch_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 16
) ();
    logic                             wr_en;
    logic [$clog2(NUM_CH + 1) - 1:0] wr_sel;
    logic [WIDTH-1:0]                 wr_data;

    modport master (output wr_en, wr_sel, wr_data);
    modport slave  (input  wr_en, wr_sel, wr_data);
endinterface

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: one shared prescaled timebase, double-buffered period and
// duty registers that swap only at the period boundary, per-channel duty clamping and a
// level-sensitive kill that masks outputs without disturbing the timebase.
module pwm_multi_ch #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned MIN_DUTY = 0,
    parameter int unsigned MAX_DUTY = 2**WIDTH - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              kill,
    input  logic [WIDTH-1:0]  prescale,
    pwm_multi_ch_if.slave     bus,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start,
    output logic [WIDTH-1:0]  cnt_out
);

    localparam int unsigned      SelW      = $clog2(NUM_CH + 1);
    localparam logic [SelW-1:0]  PeriodSel = SelW'(NUM_CH);
    localparam logic [WIDTH-1:0] MinD      = WIDTH'(MIN_DUTY);
    localparam logic [WIDTH-1:0] MaxD      = WIDTH'(MAX_DUTY);

    logic [WIDTH-1:0]  psc_q, psc_d;
    // Prescale value captured at each psc wrap so a change never truncates a running count
    logic [WIDTH-1:0]  psc_max_q, psc_max_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  period_pend_q, period_pend_d;
    logic [WIDTH-1:0]  period_act_q, period_act_d;
    logic [WIDTH-1:0]  duty_pend_q [NUM_CH];
    logic [WIDTH-1:0]  duty_pend_d [NUM_CH];
    logic [WIDTH-1:0]  duty_act_q [NUM_CH];
    logic [WIDTH-1:0]  duty_act_d [NUM_CH];
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic              period_start_q, period_start_d;

    logic              tick;
    logic              boundary;
    logic [WIDTH-1:0]  duty_lo;
    logic [WIDTH-1:0]  duty_clamped;

    // Clamp stages are only built when the bound can actually bite
    if (MIN_DUTY > 0) begin : g_min_clamp
        assign duty_lo = (bus.wr_data < MinD) ? MinD : bus.wr_data;
    end else begin : g_no_min_clamp
        assign duty_lo = bus.wr_data;
    end

    if (longint'(MAX_DUTY) < (longint'(1) << WIDTH) - 1) begin : g_max_clamp
        assign duty_clamped = (duty_lo > MaxD) ? MaxD : duty_lo;
    end else begin : g_no_max_clamp
        assign duty_clamped = duty_lo;
    end

    assign tick     = (psc_q == psc_max_q);
    assign boundary = tick && (cnt_q >= period_act_q);

    // Next-state: pending writes, timebase advance, boundary swap and output compare
    always_comb begin : next_state
        psc_d          = psc_q;
        psc_max_d      = psc_max_q;
        cnt_d          = cnt_q;
        period_pend_d  = period_pend_q;
        period_act_d   = period_act_q;
        duty_pend_d    = duty_pend_q;
        duty_act_d     = duty_act_q;
        pwm_d          = '0;
        period_start_d = 1'b0;

        if (bus.wr_en) begin
            if (bus.wr_sel == PeriodSel) begin
                period_pend_d = bus.wr_data;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.wr_sel == SelW'(i)) begin
                    duty_pend_d[i] = duty_clamped;
                end
            end
        end

        if (!enable) begin
            // Idle: timebase parked at zero, active set tracks pending every cycle
            psc_d        = '0;
            psc_max_d    = prescale;
            cnt_d        = '0;
            period_act_d = period_pend_q;
            duty_act_d   = duty_pend_q;
        end else begin
            period_start_d = boundary;
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_d[i] = !kill && (cnt_q < duty_act_q[i]);
            end
            if (tick) begin
                psc_d     = '0;
                psc_max_d = prescale;
                cnt_d     = boundary ? '0 : cnt_q + WIDTH'(1);
            end else begin
                psc_d = psc_q + WIDTH'(1);
            end
            // Swap takes the pending values as they stood before this cycle's write
            if (boundary) begin
                period_act_d = period_pend_q;
                duty_act_d   = duty_pend_q;
            end
        end
    end

    // State register with synchronous reset that overrides any coincident write
    always_ff @(posedge clk) begin : state_reg
        if (reset) begin
            psc_q          <= '0;
            psc_max_q      <= '0;
            cnt_q          <= '0;
            period_pend_q  <= '0;
            period_act_q   <= '0;
            duty_pend_q    <= '{default: '0};
            duty_act_q     <= '{default: '0};
            pwm_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            psc_q          <= psc_d;
            psc_max_q      <= psc_max_d;
            cnt_q          <= cnt_d;
            period_pend_q  <= period_pend_d;
            period_act_q   <= period_act_d;
            duty_pend_q    <= duty_pend_d;
            duty_act_q     <= duty_act_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = period_start_q;
    assign cnt_out      = cnt_q;

endmodule
